// File: rtl/scnn_wt_streamer.sv
// Weight streamer: captures one compressed weight vector and replays it
// as PARAM_F-lane beats tagged with absolute filter positions.
module scnn_wt_streamer #(
  parameter int PARAM_WSIZE = 25,
  parameter int PARAM_F     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [7:0]                    non_zero,
  input  logic [PARAM_WSIZE-1:0][15:0]  comp_arr,
  input  logic [PARAM_WSIZE-1:0][7:0]   comp_ind,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PARAM_F-1:0][15:0]      out_wt,
  output logic [PARAM_F-1:0][7:0]       out_pos,
  output logic [PARAM_F-1:0]            out_lane_en,
  output logic                          out_last
);

  localparam int IW = (PARAM_WSIZE > 1) ? $clog2(PARAM_WSIZE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_EMPTY  = 2'd2;

  logic [1:0]                   r_state;
  logic [PARAM_WSIZE-1:0][15:0] r_wt;
  logic [PARAM_WSIZE-1:0][7:0]  r_ind;
  logic [7:0]                   r_cnt;
  logic [7:0]                   r_ptr;
  logic [7:0]                   r_base;

  logic [7:0]                   w_cnt_clamp;
  logic [8:0]                   w_sum;
  logic [IW-1:0]                w_ix;
  logic [7:0]                   w_acc;
  logic [7:0]                   w_lastp;
  logic [PARAM_F-1:0][15:0]     w_wt;
  logic [PARAM_F-1:0][7:0]      w_pos;
  logic [PARAM_F-1:0]           w_en;
  logic                         w_last;

  assign w_cnt_clamp = (non_zero > 8'(PARAM_WSIZE)) ?
                       8'(PARAM_WSIZE) : non_zero;

  // Positions accumulate lane by lane: each lane adds its zero run
  // plus one slot for the previous lane's own weight.
  always_comb begin
    w_wt    = '0;
    w_pos   = '0;
    w_en    = '0;
    w_acc   = r_base;
    w_lastp = r_base;
    w_sum   = '0;
    w_ix    = '0;
    if (r_state == S_STREAM) begin
      for (int l = 0; l < PARAM_F; l++) begin
        w_sum = {1'b0, r_ptr} + 9'(l);
        if (w_sum < {1'b0, r_cnt}) begin
          w_ix     = w_sum[IW-1:0];
          w_en[l]  = 1'b1;
          w_acc    = w_acc + r_ind[w_ix] + ((l == 0) ? 8'd0 : 8'd1);
          w_wt[l]  = r_wt[w_ix];
          w_pos[l] = w_acc;
          w_lastp  = w_acc;
        end
      end
    end
  end

  assign w_last = ({1'b0, r_ptr} + 9'(PARAM_F)) >= {1'b0, r_cnt};

  assign load_ready  = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_STREAM) || (r_state == S_EMPTY);
  assign out_wt      = w_wt;
  assign out_pos     = w_pos;
  assign out_lane_en = w_en;
  assign out_last    = (r_state == S_EMPTY) ||
                       ((r_state == S_STREAM) && w_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wt    <= '0;
      r_ind   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_base  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_wt    <= comp_arr;
            r_ind   <= comp_ind;
            r_cnt   <= w_cnt_clamp;
            r_ptr   <= '0;
            r_base  <= '0;
            r_state <= (w_cnt_clamp == 8'd0) ? S_EMPTY : S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            r_ptr  <= r_ptr + 8'(PARAM_F);
            r_base <= w_lastp + 8'd1;
            if (w_last) r_state <= S_IDLE;
          end
        end
        S_EMPTY: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scnn_wt_streamer.sv
// Scoreboard bench for scnn_wt_streamer: stimulus pushes expected beats,
// a negedge monitor compares every presented beat against the queue.
module tb_scnn_wt_streamer;

  localparam int WS = 25;
  localparam int F  = 4;

  typedef struct packed {
    logic [F-1:0][15:0] wt;
    logic [F-1:0][7:0]  pos;
    logic [F-1:0]       en;
    logic               last;
  } beat_t;

  logic                 clk;
  logic                 reset;
  logic                 load_valid;
  logic                 load_ready;
  logic [7:0]           non_zero;
  logic [WS-1:0][15:0]  comp_arr;
  logic [WS-1:0][7:0]   comp_ind;
  logic                 out_valid;
  logic                 out_ready;
  logic [F-1:0][15:0]   out_wt;
  logic [F-1:0][7:0]    out_pos;
  logic [F-1:0]         out_lane_en;
  logic                 out_last;

  scnn_wt_streamer #(.PARAM_WSIZE(WS), .PARAM_F(F)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .non_zero    (non_zero),
    .comp_arr    (comp_arr),
    .comp_ind    (comp_ind),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wt      (out_wt),
    .out_pos     (out_pos),
    .out_lane_en (out_lane_en),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t q[$];
  bit    chk_lr   = 0;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic beat_t mk(input logic [15:0] w0, w1, w2, w3,
                               input logic [7:0] p0, p1, p2, p3,
                               input logic [3:0] en, input logic last);
    beat_t b;
    b.wt[0] = w0; b.wt[1] = w1; b.wt[2] = w2; b.wt[3] = w3;
    b.pos[0] = p0; b.pos[1] = p1; b.pos[2] = p2; b.pos[3] = p3;
    b.en = en;
    b.last = last;
    return b;
  endfunction

  // Monitor: compare whatever beat is presented, pop on acceptance.
  always begin
    @(negedge clk);
    if (chk_lr) begin
      chk_lr = 0;
      check("load_ready_after_last", {out_valid, load_ready}, 2'b01);
    end else if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_beat", {out_valid}, 1'b0);
      end else begin
        check("beat", {out_wt, out_pos, out_lane_en, out_last}, q[0]);
        if (out_ready) begin
          if (q[0].last) chk_lr = 1;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_partial();
    q.push_back(mk(1, 2, 3, 4, 0, 1, 5, 6, 4'b1111, 1'b0));
    q.push_back(mk(5, 6, 0, 0, 8, 11, 0, 0, 4'b0011, 1'b1));
  endtask

  task automatic push_dense(input logic [15:0] wbase);
    beat_t b;
    for (int bi = 0; bi < 7; bi++) begin
      b = '0;
      for (int l = 0; l < F; l++) begin
        if (bi * F + l < WS) begin
          b.wt[l]  = wbase + 16'(bi * F + l);
          b.pos[l] = 8'(bi * F + l);
          b.en[l]  = 1'b1;
        end
      end
      b.last = (bi == 6);
      q.push_back(b);
    end
  endtask

  task automatic set_partial();
    logic [7:0] ind [6];
    ind = '{0, 0, 3, 0, 1, 2};
    comp_arr = '0;
    comp_ind = '0;
    for (int i = 0; i < 6; i++) begin
      comp_arr[i] = 16'(i + 1);
      comp_ind[i] = ind[i];
    end
    non_zero = 8'd6;
  endtask

  task automatic set_dense(input logic [15:0] wbase, input logic [7:0] nz);
    comp_ind = '0;
    for (int i = 0; i < WS; i++) comp_arr[i] = wbase + 16'(i);
    non_zero = nz;
  endtask

  task automatic do_load(input string nm);
    int i;
    for (i = 0; i < 50 && !load_ready; i++) begin
      @(posedge clk); #1;
    end
    check({nm, "_ready_timeout"}, {load_ready}, 1'b1);
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check({nm, "_latency"}, {out_valid}, 1'b1);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      if (q.size() == 0 && !chk_lr) break;
      @(posedge clk); #1;
    end
    check({nm, "_drain"}, {q.size() == 0 && !chk_lr}, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    non_zero   = '0;
    comp_arr   = '0;
    comp_ind   = '0;
    #2;
    check("rst_out_valid", {out_valid}, 1'b0);
    check("rst_load_ready", {load_ready}, 1'b1);
    check("rst_lane_en", {out_lane_en}, 4'b0);
    check("rst_last", {out_last}, 1'b0);
    check("rst_wt", {out_wt}, 64'h0);
    check("rst_pos", {out_pos}, 32'h0);

    // A load held during reset must be ignored.
    set_partial();
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("load_in_reset_ignored", {out_valid, load_ready}, 2'b01);

    // Partial second beat
    out_ready = 1'b1;
    set_partial();
    push_partial();
    do_load("partial");
    wait_done("partial");

    // Empty vector
    non_zero = 8'd0;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1'b1));
    do_load("empty");
    wait_done("empty");

    // Dense vector
    set_dense(16'h0100, 8'd25);
    push_dense(16'h0100);
    do_load("dense");
    wait_done("dense");

    // Backpressure on beat 0 for three cycles
    out_ready = 1'b0;
    set_partial();
    push_partial();
    do_load("bp");
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done("bp");

    // Reset during beat 0 of a dense vector
    out_ready = 1'b0;
    set_dense(16'h0300, 8'd25);
    push_dense(16'h0300);
    do_load("rst_mid");
    @(negedge clk); #1;
    reset = 1'b1;
    q.delete();
    chk_lr = 0;
    #1;
    check("rst_mid_out_valid", {out_valid}, 1'b0);
    check("rst_mid_load_ready", {load_ready}, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    set_partial();
    push_partial();
    do_load("after_rst");
    wait_done("after_rst");

    // Clamp: non_zero above vector length
    set_dense(16'h0200, 8'd30);
    push_dense(16'h0200);
    do_load("clamp");
    wait_done("clamp");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scnn_wt_streamer.md
# scnn_wt_streamer

Sequential stage directly downstream of the weight compressor. Captures one compressed weight vector, meaning the non-zero values, their zero-run indices and the non-zero count. It then streams the weights to the multiplier array as PARAM_F-lane beats, each weight paired with its reconstructed absolute filter position. Beats use a valid/ready handshake, so the multiplier array can stall the stream.

## Interface
- PARAM_WSIZE, 25: weight vector length; must be ≤ 255.
- PARAM_F, 4: lanes per output beat; must be ≥ 1 and ≤ PARAM_WSIZE.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  a compressed vector is presented.
- load_ready  output  1  streamer can accept a vector; high only in IDLE.
- non_zero  input  8  count of valid entries in comp_arr/comp_ind.
- comp_arr  input  [PARAM_WSIZE-1:0][15:0]  packed non-zero weights, entry 0 first.
- comp_ind  input  [PARAM_WSIZE-1:0][7:0]  zero-run length preceding each packed weight.
- out_valid  output  1  beat present.
- out_ready  input  1  consumer accepts beat.
- out_wt  output  [PARAM_F-1:0][15:0]  lane weights.
- out_pos  output  [PARAM_F-1:0][7:0]  lane absolute positions (0..PARAM_WSIZE-1).
- out_lane_en  output  PARAM_F  per-lane valid mask.
- out_last  output  1  final beat of the current vector.

## Operation
- States are IDLE, STREAM and EMPTY. Registers:
  - captured wt_q and ind_q;
  - count cnt_q, clamped to PARAM_WSIZE when non_zero > PARAM_WSIZE;
  - read pointer ptr_q;
  - position base base_q.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid, capture comp_arr, comp_ind and the clamped count, and set ptr_q=0, base_q=0.
  - Go to EMPTY if the clamped count is 0, else go to STREAM.
- STREAM:
  - out_valid=1.
  - Lane l is enabled when ptr_q+l < cnt_q.
  - Lane l weight is out_wt[l]=wt_q[ptr_q+l].
  - Lane l position: out_pos[l] = base_q + Σ_{m=0..l} ind_q[ptr_q+m] + l.
  - Disabled lanes drive out_wt=0 and out_pos=0.
  - out_last=1 when ptr_q+PARAM_F ≥ cnt_q.
- STREAM, on out_valid & out_ready:
  - ptr_q += PARAM_F.
  - base_q = out_pos[last enabled lane] + 1.
  - If out_last, go to IDLE.
- EMPTY:
  - Presents one beat: out_valid=1, out_lane_en=0, out_last=1, out_wt=0, out_pos=0.
  - Goes to IDLE on out_ready.
- Outputs are functions of registered state only; there is no combinational path from out_ready or load_valid to any output.
- Arithmetic is 8-bit unsigned and wraps modulo 256. Correct positions are guaranteed only for well-formed input, i.e. Σind + non_zero ≤ PARAM_WSIZE. No error flag is raised.
- comp_arr/comp_ind entries at index ≥ cnt_q are never read.

## Timing
- Reset values:
  - state=IDLE, ptr_q=0, base_q=0, cnt_q=0;
  - out_valid=0, out_lane_en=0, out_last=0, out_wt=0, out_pos=0;
  - load_ready=1.
- load_valid is ignored while reset is high.
- Load latency: a load accepted at edge N gives out_valid=1 in the cycle after edge N, with beat 0 on the outputs.
- Throughput: one beat per cycle while out_ready=1. A vector of n≥1 weights takes ceil(n/PARAM_F) beats.
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals hold stable.
- After the final beat is accepted at edge M, load_ready=1 in the cycle after M. There is one bubble cycle between vectors; no back-to-back overlap.
- Reset asserted mid-stream immediately forces out_valid=0 and returns to IDLE. The partial vector is discarded.
- out_ready while out_valid=0 has no effect.

## Test plan
- Partial second beat (PARAM_WSIZE=25, PARAM_F=4):
  - Stimulus: non_zero=6, comp_arr[0..5]=1..6, comp_ind[0..5]={0,0,3,0,1,2}, out_ready=1.
  - Beat 0: wt {1,2,3,4}, pos {0,1,5,6}, lane_en 1111, last=0.
  - Beat 1: wt {5,6,0,0}, pos {8,11,0,0}, lane_en 0011, last=1.
  - load_ready=1 one cycle after beat 1 is accepted.
- Empty vector: non_zero=0 -> exactly one beat the cycle after load, lane_en 0000, last=1; back to IDLE on out_ready.
- Dense vector: non_zero=25, all comp_ind=0 -> 7 beats. Beat 6 has lane_en 0001, pos[0]=24, last=1.
- Backpressure: same stimulus as the partial-second-beat case with out_ready=0 for 3 cycles after the first beat appears -> beat 0 held bit-identical for those cycles; beat 1 follows one cycle after out_ready rises.
- Reset mid-stream: assert reset during beat 0 of the dense vector -> out_valid=0 in the same cycle, load_ready=1. A fresh load afterwards streams correctly from pos 0.
- Clamp: non_zero=30 with comp_ind=0 -> treated as 25, giving 7 beats, final pos 24.
